// File: rtl/exposure_timer_ctrl.sv
// exposure_timer_ctrl: drives the 2-bit opcode of an external 8-bit up-counter
// (00 hold, 01 increment, 10 clear) and uses its count to time a lamp-enable
// window of `preset` cycles, with start, pause/resume and abort.
// Optional build macro TIMER_PAUSE_TIMEOUT_EN: a pause held for MAX_PAUSE
// cycles aborts the sequence.
module exposure_timer_ctrl #(
  parameter int n         = 8,
  parameter int MAX_PAUSE = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pause,
  input  logic         abort,
  input  logic [n-1:0] preset,
  input  logic [n-1:0] cnt,
  output logic [1:0]   opc,
  output logic         active,
  output logic         busy,
  output logic         done,
  output logic         aborted
);

  localparam logic [1:0] OPC_HOLD = 2'b00;
  localparam logic [1:0] OPC_INC  = 2'b01;
  localparam logic [1:0] OPC_CLR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_PAUSE,
    S_DONE
  } state_t;

  state_t       state;
  logic [n-1:0] limit_q;
  logic         at_limit;
  logic         pause_expired;

  // Reject a pause limit that could never be reached
  if (MAX_PAUSE < 1) begin : g_bad_max_pause
    $error("exposure_timer_ctrl: MAX_PAUSE must be at least 1");
  end

  assign at_limit = (cnt == limit_q);

`ifdef TIMER_PAUSE_TIMEOUT_EN
  localparam int unsigned PW = $clog2(MAX_PAUSE + 1);

  logic [PW-1:0] pause_cnt;

  // Pause-length counter: zeroed while running, advances each PAUSE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pause_cnt <= '0;
    end else if (state == S_RUN) begin
      pause_cnt <= '0;
    end else if (state == S_PAUSE) begin
      pause_cnt <= pause_cnt + PW'(1);
    end
  end

  // Current PAUSE cycle is the MAX_PAUSE-th one
  assign pause_expired = (pause_cnt == PW'(MAX_PAUSE - 1));
`else
  assign pause_expired = 1'b0;
`endif

  // Lamp is on exactly in the cycles where the counter is told to advance
  assign active = (state == S_RUN) && !abort && !pause && !at_limit;

  // Counter opcode decoded from state and the current request inputs
  always_comb begin
    opc = OPC_HOLD;
    case (state)
      S_CLEAR: opc = OPC_CLR;
      S_RUN: begin
        if (abort) begin
          opc = OPC_CLR;
        end else if (pause || at_limit) begin
          opc = OPC_HOLD;
        end else begin
          opc = OPC_INC;
        end
      end
      S_PAUSE: begin
        if (abort || (pause && pause_expired)) begin
          opc = OPC_CLR;
        end
      end
      default: opc = OPC_HOLD;
    endcase
  end

  // Sequencing FSM with registered busy/done/aborted status
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      limit_q <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            limit_q <= preset;
            busy    <= 1'b1;
            if (preset != '0) begin
              state <= S_CLEAR;
            end else begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_CLEAR: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            state <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (pause) begin
            state <= S_PAUSE;
          end else if (at_limit) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_PAUSE: begin
          if (abort) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else if (!pause) begin
            state <= S_RUN;
          end else if (pause_expired) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exposure_timer_ctrl.sv
// Testbench for exposure_timer_ctrl: an 8-bit counter model closes the loop,
// scenarios push expected outcomes into a queue, and a monitor compares each
// done/aborted pulse against them. Honours TIMER_PAUSE_TIMEOUT_EN.
module tb_exposure_timer_ctrl;

  localparam int TB_MAX_PAUSE = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       abort;
  logic [7:0] preset;
  logic [7:0] cnt;
  logic [1:0] opc;
  logic       active;
  logic       busy;
  logic       done;
  logic       aborted;

  typedef struct {
    bit          is_abort;
    int          t;
    int          act;
    int          cnt;
    bit          busy;
    int unsigned start_cyc;
  } exp_t;

  exp_t        expq[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          env_cnt     = 0;
  int unsigned cyc         = 0;

  exposure_timer_ctrl #(
    .n(8),
    .MAX_PAUSE(TB_MAX_PAUSE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pause(pause),
    .abort(abort),
    .preset(preset),
    .cnt(cnt),
    .opc(opc),
    .active(active),
    .busy(busy),
    .done(done),
    .aborted(aborted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // External up-counter with clear, sharing the reset
  always @(posedge clk or posedge rst) begin
    if (rst) cnt <= 8'd0;
    else begin
      case (opc)
        2'b01: cnt <= cnt + 8'd1;
        2'b10: cnt <= 8'd0;
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, req, cyc);
    end
  endtask

  // Monitor: count lamp cycles, compare every status pulse with the queue head
  initial begin
    int   mon_act;
    exp_t e;
    mon_act = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_act = 0;
      end else begin
        if (active) mon_act++;
        if (done || aborted) begin
          if (expq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_pulse: done=%0b aborted=%0b with no expectation (cycle %0d)",
                     done, aborted, cyc);
          end else begin
            e = expq.pop_front();
            check("pulse_exclusive", int'(done & aborted), 0);
            check("outcome_aborted", int'(aborted), int'(e.is_abort));
            check("latency", int'(cyc - e.start_cyc), e.t);
            check("active_cycles", mon_act, e.act);
            check("cnt_at_pulse", int'(cnt), e.cnt);
            check("busy_at_pulse", int'(busy), int'(e.busy));
          end
          mon_act = 0;
        end
      end
    end
  end

  // One exposure: p=preset, optional pause starting at count c for d cycles,
  // optional abort at count a. Expected outcome is derived arithmetically.
  task automatic run_scn(input int p, input bit hp, input int c, input int d,
                         input bit ha, input int a);
    exp_t e;
    bit   timeout;
    timeout = 1'b0;
`ifdef TIMER_PAUSE_TIMEOUT_EN
    timeout = hp && (p != 0) && !ha && (d - 1 >= TB_MAX_PAUSE);
`endif
    e.start_cyc = cyc;
    if (p == 0) begin
      e.is_abort = 1'b0; e.t = 1; e.act = 0; e.cnt = env_cnt; e.busy = 1'b1;
    end else if (ha) begin
      e.is_abort = 1'b1; e.t = 3 + a; e.act = a; e.cnt = 0; e.busy = 1'b0;
    end else if (timeout) begin
      e.is_abort = 1'b1; e.t = 3 + c + TB_MAX_PAUSE; e.act = c; e.cnt = 0; e.busy = 1'b0;
    end else if (hp) begin
      e.is_abort = 1'b0; e.t = p + 4 + d; e.act = p; e.cnt = p; e.busy = 1'b1;
    end else begin
      e.is_abort = 1'b0; e.t = p + 3; e.act = p; e.cnt = p; e.busy = 1'b1;
    end
    expq.push_back(e);
    for (int t = 0; t <= e.t; t++) begin
      if (t == 0) begin
        start  = 1'b1;
        preset = 8'(p);
        abort  = 1'($urandom_range(0, 1));
      end else begin
        start  = (e.is_abort && t == e.t) ? 1'b0 : 1'($urandom_range(0, 1));
        preset = 8'($urandom_range(0, 255));
        abort  = ha && (t == 2 + a) && (p != 0);
      end
      pause = hp && (p != 0) && (t >= 2 + c) && (t <= 1 + c + d);
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
    pause = 1'b0;
    env_cnt = e.cnt;
    // idle gap: abort and pause in IDLE must be ignored
    for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
      abort  = 1'($urandom_range(0, 1));
      pause  = 1'($urandom_range(0, 1));
      preset = 8'($urandom_range(0, 255));
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
    pause = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, kind, c, d, a;
    rst = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; preset = 8'd0;
    #12;
    check("reset_opc", int'(opc), 0);
    check("reset_active", int'(active), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_aborted", int'(aborted), 0);
    check("reset_cnt", int'(cnt), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_scn(5, 0, 0, 0, 0, 0);
    run_scn(10, 1, 4, 3, 0, 0);
    run_scn(8, 0, 0, 0, 1, 3);
    run_scn(0, 0, 0, 0, 0, 0);
    run_scn(255, 0, 0, 0, 0, 0);
    run_scn(0, 0, 0, 0, 0, 0);
    run_scn(6, 1, 6, 2, 0, 0);
    run_scn(7, 0, 0, 0, 1, 0);
    run_scn(7, 0, 0, 0, 1, 7);
    run_scn(3, 1, 1, 4, 0, 0);
    run_scn(3, 1, 1, 5, 0, 0);
    run_scn(6, 1, 2, 300, 0, 0);

    // asynchronous reset in the middle of a run
    start = 1'b1; preset = 8'd50;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    #2;
    rst = 1'b1;
    #1;
    check("midrun_reset_active", int'(active), 0);
    check("midrun_reset_busy", int'(busy), 0);
    check("midrun_reset_opc", int'(opc), 0);
    check("midrun_reset_cnt", int'(cnt), 0);
    env_cnt = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 40; i++) begin
      p    = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
      kind = int'($urandom_range(0, 2));
      c    = int'($urandom_range(0, p));
      d    = int'($urandom_range(1, 8));
      a    = int'($urandom_range(0, p));
      run_scn(p, kind == 1, c, d, kind == 2, a);
    end

    for (int w = 0; w < 50 && expq.size() != 0; w++) begin
      @(posedge clk); #1;
    end
    if (expq.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_expectations: %0d outcomes never observed", expq.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
